// File: rtl/npu_dsp_pkg.sv
// Shared widths, operand/product types and the unsigned multiply helper for the DSP multiplier bank.
package npu_dsp_pkg;

    localparam int DSP_OP_W  = 18;
    localparam int DSP_P_W   = 37;
    localparam int DSP_LANES = 5;

    typedef logic [DSP_OP_W-1:0] dsp_op_t;
    typedef logic [DSP_P_W-1:0]  dsp_prod_t;

    // Full 36-bit unsigned product, zero-extended into the 37-bit result width.
    function automatic dsp_prod_t dsp_mul(input dsp_op_t a, input dsp_op_t b);
        logic [2*DSP_OP_W-1:0] p;
        p = {{DSP_OP_W{1'b0}}, a} * {{DSP_OP_W{1'b0}}, b};
        return {1'b0, p};
    endfunction

endpackage

// File: rtl/dsp_mult_bank_if.sv
// Operand/result bundle between matrix_multiplier (master) and the DSP bank (slave).
// acc_clr exists only when DSP_ACCUM_EN is defined.
interface dsp_mult_bank_if #(parameter int LANES = npu_dsp_pkg::DSP_LANES) ();
    import npu_dsp_pkg::*;

    logic                  dsp_ce;
    dsp_op_t   [LANES-1:0] dsp_a0;
    dsp_op_t   [LANES-1:0] dsp_b0;
`ifdef DSP_ACCUM_EN
    logic                  acc_clr;
`endif
    dsp_prod_t [LANES-1:0] dsp_out;
    logic                  dsp_out_vld;

`ifdef DSP_ACCUM_EN
    modport master (output dsp_ce, dsp_a0, dsp_b0, acc_clr, input dsp_out, dsp_out_vld);
    modport slave  (input dsp_ce, dsp_a0, dsp_b0, acc_clr, output dsp_out, dsp_out_vld);
`else
    modport master (output dsp_ce, dsp_a0, dsp_b0, input dsp_out, dsp_out_vld);
    modport slave  (input dsp_ce, dsp_a0, dsp_b0, output dsp_out, dsp_out_vld);
`endif

endinterface

// File: rtl/dsp_lane.sv
// One multiplier lane: operand capture, product pipeline and output register.
// With DSP_ACCUM_EN defined the output register becomes a wrapping accumulator.
module dsp_lane
    import npu_dsp_pkg::*;
#(
    parameter int PIPE_STAGES = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ce,
    input  logic      load,
`ifdef DSP_ACCUM_EN
    input  logic      clr,
`endif
    input  dsp_op_t   a,
    input  dsp_op_t   b,
    output dsp_prod_t result
);

    dsp_prod_t final_prod;

    generate
        if (PIPE_STAGES == 1) begin : g_direct
            // Single stage: the output register itself captures the product, so ce only arrives via load.
            logic unused_ce;
            assign unused_ce  = ce;
            assign final_prod = dsp_mul(a, b);
        end else begin : g_pipe
            dsp_op_t a_q;
            dsp_op_t b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (ce) begin
                    a_q <= a;
                    b_q <= b;
                end
            end

            if (PIPE_STAGES == 2) begin : g_s2
                assign final_prod = dsp_mul(a_q, b_q);
            end else begin : g_sn
                dsp_prod_t prod_q [PIPE_STAGES-2];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int i = 0; i < PIPE_STAGES-2; i++) prod_q[i] <= '0;
                    end else if (ce) begin
                        prod_q[0] <= dsp_mul(a_q, b_q);
                        for (int i = 1; i < PIPE_STAGES-2; i++) prod_q[i] <= prod_q[i-1];
                    end
                end

                assign final_prod = prod_q[PIPE_STAGES-3];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else if (load) begin
`ifdef DSP_ACCUM_EN
            result <= clr ? final_prod : result + final_prod;
`else
            result <= final_prod;
`endif
        end
    end

endmodule

// File: rtl/dsp_mult_bank.sv
// Bank of LANES unsigned 18x18 multiplier lanes sharing ce, valid chain and reset.
// Optional output accumulation with acc_clr is enabled by defining DSP_ACCUM_EN.
module dsp_mult_bank
    import npu_dsp_pkg::*;
#(
    parameter int LANES       = DSP_LANES,
    parameter int PIPE_STAGES = 1
) (
    input logic            clk,
    input logic            rst_n,
    dsp_mult_bank_if.slave bus
);

    logic                  final_vld;
    logic                  load;
    dsp_prod_t [LANES-1:0] lane_out;
`ifdef DSP_ACCUM_EN
    logic                  final_clr;
`endif

    // The valid (and clear) chains mirror the lane stages so a result and its control bits stay aligned.
    generate
        if (PIPE_STAGES == 1) begin : g_ctl_direct
            assign final_vld = 1'b1;
`ifdef DSP_ACCUM_EN
            assign final_clr = bus.acc_clr;
`endif
        end else begin : g_ctl_chain
            logic [PIPE_STAGES-2:0] vld_q;
`ifdef DSP_ACCUM_EN
            logic [PIPE_STAGES-2:0] clr_q;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
`ifdef DSP_ACCUM_EN
                    clr_q <= '0;
`endif
                end else if (bus.dsp_ce) begin
                    vld_q[0] <= 1'b1;
                    for (int i = 1; i < PIPE_STAGES-1; i++) vld_q[i] <= vld_q[i-1];
`ifdef DSP_ACCUM_EN
                    clr_q[0] <= bus.acc_clr;
                    for (int i = 1; i < PIPE_STAGES-1; i++) clr_q[i] <= clr_q[i-1];
`endif
                end
            end

            assign final_vld = vld_q[PIPE_STAGES-2];
`ifdef DSP_ACCUM_EN
            assign final_clr = clr_q[PIPE_STAGES-2];
`endif
        end
    endgenerate

    assign load = bus.dsp_ce & final_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.dsp_out_vld <= 1'b0;
        else        bus.dsp_out_vld <= load;
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            dsp_lane #(.PIPE_STAGES(PIPE_STAGES)) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .ce     (bus.dsp_ce),
                .load   (load),
`ifdef DSP_ACCUM_EN
                .clr    (final_clr),
`endif
                .a      (bus.dsp_a0[l]),
                .b      (bus.dsp_b0[l]),
                .result (lane_out[l])
            );
        end
    endgenerate

    assign bus.dsp_out = lane_out;

endmodule

// File: tb/tb_dsp_mult_bank.sv
// Bench driving three banks (PIPE_STAGES 1, 2, 3) with identical operand streams and checking each.
// Accumulator sequences are included when DSP_ACCUM_EN is defined.
module tb_dsp_mult_bank;
    import npu_dsp_pkg::*;

    typedef struct packed {
        logic [4:0][17:0] a;
        logic [4:0][17:0] b;
        logic [4:0][36:0] p;
    } vec_t;

    typedef struct {
        logic ce;
        int   op;
        int   exp1, exp2, exp3;
        logic v1, v2, v3;
    } step_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    vec_t vec [5];
    step_t seq_a [6];
    step_t seq_b [8];

    always #5 clk = ~clk;

    dsp_mult_bank_if #(.LANES(5)) bus1 ();
    dsp_mult_bank_if #(.LANES(5)) bus2 ();
    dsp_mult_bank_if #(.LANES(5)) bus3 ();

    dsp_mult_bank #(.LANES(5), .PIPE_STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    dsp_mult_bank #(.LANES(5), .PIPE_STAGES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    dsp_mult_bank #(.LANES(5), .PIPE_STAGES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

`ifdef DSP_ACCUM_EN
    // Clear held high outside the accumulator sequences so every result is a plain product.
    logic acc_clr_drv = 1'b1;
    assign bus1.acc_clr = acc_clr_drv;
    assign bus2.acc_clr = acc_clr_drv;
    assign bus3.acc_clr = acc_clr_drv;
`endif

    function automatic step_t mk(input logic ce, input int op, input int e1, input int e2,
                                 input int e3, input logic v1, input logic v2, input logic v3);
        step_t s;
        s.ce = ce; s.op = op; s.exp1 = e1; s.exp2 = e2; s.exp3 = e3;
        s.v1 = v1; s.v2 = v2; s.v3 = v3;
        return s;
    endfunction

    function automatic logic [36:0] expOut(input int idx, input int lane);
        if (idx < 0) return '0;
        return vec[idx].p[lane];
    endfunction

    task automatic checkOutput(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic [4:0][17:0] a, input logic [4:0][17:0] b);
        bus1.dsp_ce = ce; bus1.dsp_a0 = a; bus1.dsp_b0 = b;
        bus2.dsp_ce = ce; bus2.dsp_a0 = a; bus2.dsp_b0 = b;
        bus3.dsp_ce = ce; bus3.dsp_a0 = a; bus3.dsp_b0 = b;
    endtask

    task automatic checkAll(input string tag, input step_t s);
        for (int l = 0; l < 5; l++) begin
            checkOutput($sformatf("%s p1 lane%0d", tag, l), bus1.dsp_out[l], expOut(s.exp1, l));
            checkOutput($sformatf("%s p2 lane%0d", tag, l), bus2.dsp_out[l], expOut(s.exp2, l));
            checkOutput($sformatf("%s p3 lane%0d", tag, l), bus3.dsp_out[l], expOut(s.exp3, l));
        end
        checkOutput($sformatf("%s p1 vld", tag), {36'b0, bus1.dsp_out_vld}, {36'b0, s.v1});
        checkOutput($sformatf("%s p2 vld", tag), {36'b0, bus2.dsp_out_vld}, {36'b0, s.v2});
        checkOutput($sformatf("%s p3 vld", tag), {36'b0, bus3.dsp_out_vld}, {36'b0, s.v3});
    endtask

    // Present one step's operands, take one edge, then compare all three banks.
    task automatic applyStimulus(input string tag, input step_t s);
        drive(s.ce, vec[s.op].a, vec[s.op].b);
        @(posedge clk);
        #1;
        checkAll(tag, s);
    endtask

`ifdef DSP_ACCUM_EN
    task automatic accStep(input logic [17:0] k, input logic clr);
        logic [4:0][17:0] v;
        v = '0;
        v[0] = k;
        acc_clr_drv = clr;
        drive(1'b1, v, v);
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        // Concatenations list lane4 first, lane0 last.
        vec[0].a = {18'd100, 18'h3FFFF, 18'd1, 18'd0, 18'd3};
        vec[0].b = {18'd200, 18'd1, 18'd1, 18'd5, 18'd4};
        vec[0].p = {37'd20000, 37'h3FFFF, 37'd1, 37'd0, 37'd12};
        vec[1].a = {5{18'h3FFFF}};
        vec[1].b = {5{18'h3FFFF}};
        vec[1].p = {5{37'h0FFFF80001}};
        vec[2].a = {18'h12, 18'd1000, 18'h20000, 18'd7, 18'd2};
        vec[2].b = {18'h10, 18'd1000, 18'd2, 18'd9, 18'd3};
        vec[2].p = {37'h120, 37'd1000000, 37'h40000, 37'd63, 37'd6};
        vec[3].a = {18'd0, 18'h3FFFF, 18'd12345, 18'hFFFF, 18'h10000};
        vec[3].b = {18'h3FFFF, 18'd2, 18'd10, 18'hFFFF, 18'h10000};
        vec[3].p = {37'd0, 37'h7FFFE, 37'd123450, 37'hFFFE0001, 37'h100000000};
        vec[4].a = {18'd5, 18'd4, 18'd3, 18'd2, 18'd1};
        vec[4].b = {18'd50, 18'd40, 18'd30, 18'd20, 18'd10};
        vec[4].p = {37'd250, 37'd160, 37'd90, 37'd40, 37'd10};

        seq_a[0] = mk(1, 0,  0, -1, -1, 1, 0, 0);
        seq_a[1] = mk(1, 1,  1,  0, -1, 1, 1, 0);
        seq_a[2] = mk(1, 2,  2,  1,  0, 1, 1, 1);
        seq_a[3] = mk(1, 3,  3,  2,  1, 1, 1, 1);
        seq_a[4] = mk(1, 4,  4,  3,  2, 1, 1, 1);
        seq_a[5] = mk(0, 1,  4,  3,  2, 0, 0, 0);

        seq_b[0] = mk(0, 1, -1, -1, -1, 0, 0, 0);
        seq_b[1] = mk(1, 2,  2, -1, -1, 1, 0, 0);
        seq_b[2] = mk(0, 1,  2, -1, -1, 0, 0, 0);
        seq_b[3] = mk(1, 3,  3,  2, -1, 1, 1, 0);
        seq_b[4] = mk(0, 1,  3,  2, -1, 0, 0, 0);
        seq_b[5] = mk(1, 4,  4,  3,  2, 1, 1, 1);
        seq_b[6] = mk(1, 0,  0,  4,  3, 1, 1, 1);
        seq_b[7] = mk(0, 1,  0,  4,  3, 0, 0, 0);

        drive(1'b0, '0, '0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 checkAll("reset", mk(0, 0, -1, -1, -1, 0, 0, 0));
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] back-to-back vectors");
        for (int i = 0; i < 6; i++) applyStimulus($sformatf("b2b%0d", i), seq_a[i]);

        $display("[TB] reset with products in flight");
        #3 rst_n = 1'b0;
        #1 checkAll("midreset", mk(0, 0, -1, -1, -1, 0, 0, 0));
        @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] ce toggling after reset release");
        for (int i = 0; i < 8; i++) applyStimulus($sformatf("tog%0d", i), seq_b[i]);

`ifdef DSP_ACCUM_EN
        $display("[TB] accumulator runs");
        for (int k = 1; k <= 16; k++) accStep(18'(k), k == 1);
        checkOutput("acc16 p1", bus1.dsp_out[0], 37'd1496);
        accStep(18'd0, 1'b0);
        accStep(18'd0, 1'b0);
        checkOutput("acc16 p1 flushed", bus1.dsp_out[0], 37'd1496);
        checkOutput("acc16 p2", bus2.dsp_out[0], 37'd1496);
        checkOutput("acc16 p3", bus3.dsp_out[0], 37'd1496);
        accStep(18'd5, 1'b1);
        checkOutput("accrestart p1", bus1.dsp_out[0], 37'd25);
        accStep(18'd2, 1'b0);
        checkOutput("accsecond p1", bus1.dsp_out[0], 37'd29);
        accStep(18'd0, 1'b0);
        accStep(18'd0, 1'b0);
        checkOutput("accsecond p2", bus2.dsp_out[0], 37'd29);
        checkOutput("accsecond p3", bus3.dsp_out[0], 37'd29);
        acc_clr_drv = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
